// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder for an LED frame controller: config load,
// pixel streaming into frame RAM and refresh requests to the LED driver.
module spi_cmd_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int CFG_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_cs_n_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  drv_busy_i,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [7:0]            ram_wr_data_o,
    output logic [CFG_WIDTH-1:0]  cfg_data_o,
    output logic                  refresh_o
);

    localparam logic [7:0] CMD_CONF    = 8'h2A;
    localparam logic [7:0] CMD_PIXEL   = 8'h2B;
    localparam logic [7:0] CMD_REFRESH = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONF,
        ST_PIXEL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic cs_meta;
    logic cs_sync;

    logic is_conf;
    logic is_pixel;
    logic is_refresh;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  full;
    logic                  full_nxt;
    logic                  pending;
    logic                  pending_nxt;
    logic                  ref_req;

    logic                  wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [7:0]            wr_data_nxt;
    logic [CFG_WIDTH-1:0]  cfg_nxt;
    logic                  refresh_nxt;

    // Chip select crosses in from the SPI domain; idle level is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
        end else begin
            cs_meta <= spi_cs_n_i;
            cs_sync <= cs_meta;
        end
    end

    assign is_conf    = byte_vld_i && (byte_data_i == CMD_CONF);
    assign is_pixel   = byte_vld_i && (byte_data_i == CMD_PIXEL);
    assign is_refresh = byte_vld_i && (byte_data_i == CMD_REFRESH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                unique case (1'b1)
                    is_conf:  state_nxt = ST_CONF;
                    is_pixel: state_nxt = ST_PIXEL;
                    default:  state_nxt = ST_IDLE;
                endcase
            end
            ST_CONF: begin
                if (byte_vld_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PIXEL: state_nxt = ST_PIXEL;
            default:  state_nxt = ST_IDLE;
        endcase
        // A byte in the same cycle is still handled by the
        // output logic for the current state.
        if (cs_sync) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = ram_wr_addr_o;
        wr_data_nxt = ram_wr_data_o;
        cfg_nxt     = cfg_data_o;
        addr_nxt    = addr;
        full_nxt    = full;
        ref_req     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_pixel) begin
                    addr_nxt = '0;
                    full_nxt = 1'b0;
                end
                ref_req = is_refresh;
            end
            ST_CONF: begin
                if (byte_vld_i) begin
                    cfg_nxt = CFG_WIDTH'(byte_data_i);
                end
            end
            ST_PIXEL: begin
                // Saturate at the top of the frame RAM.
                if (byte_vld_i && !full) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = addr;
                    wr_data_nxt = byte_data_i;
                    if (&addr) begin
                        full_nxt = 1'b1;
                    end else begin
                        addr_nxt = addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                addr_nxt = addr;
            end
        endcase
        // Requests while busy coalesce into a single later pulse.
        refresh_nxt = (ref_req || pending) && !drv_busy_i && !refresh_o;
        pending_nxt = (ref_req || pending) && !refresh_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr          <= '0;
            full          <= 1'b0;
            pending       <= 1'b0;
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= '0;
            cfg_data_o    <= '0;
            refresh_o     <= 1'b0;
        end else begin
            addr          <= addr_nxt;
            full          <= full_nxt;
            pending       <= pending_nxt;
            ram_wr_en_o   <= wr_en_nxt;
            ram_wr_addr_o <= wr_addr_nxt;
            ram_wr_data_o <= wr_data_nxt;
            cfg_data_o    <= cfg_nxt;
            refresh_o     <= refresh_nxt;
        end
    end

endmodule
